mbgd_batch_sequencer: RTL and testbench

Sequences the mini-batch gradient-descent row-sum adder across one mini-batch. It accepts `BATCH` rows of `N` dot products over a valid/ready stream and issues each row to the registered adder tree with a one-cycle enable. It accumulates the returned row sums into a batch total and presents the total on a valid/ready output. It sits between the dot-product array and the weight-update stage.

---
 rtl/mbgd_batch_sequencer.sv | 122 ++++++++++++
 tb/tb_mbgd_batch_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbgd_batch_sequencer.sv
// Mini-batch sequencer for the gradient-descent row-sum adder tree.
// Accepts BATCH rows of N dot products, issues each to the registered adder
// tree with a one-cycle enable, accumulates the returned row sums and
// presents the batch total over a valid/ready handshake.
module mbgd_batch_sequencer #(
  parameter int N     = 8,
  parameter int N_BIT = 3,
  parameter int DW    = 8,
  parameter int BATCH = 4,
  parameter int B_BIT = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [2*DW*N-1:0]               in_data,
  output logic                            add_en,
  output logic [2*DW*N-1:0]               add_data,
  input  logic [2*DW+N_BIT-1:0]           add_sum,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*DW+N_BIT+B_BIT-1:0]     out_sum,
  output logic                            busy,
  output logic [B_BIT-1:0]                row_cnt
);

  localparam int SW = 2*DW + N_BIT;
  localparam int AW = SW + B_BIT;
  localparam logic [B_BIT-1:0] LAST_ROW = B_BIT'(BATCH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    ACC,
    DONE
  } state_t;

  state_t              state_q,    state_d;
  logic [AW-1:0]       acc_q,      acc_d;
  logic [AW-1:0]       out_sum_q,  out_sum_d;
  logic [B_BIT-1:0]    row_cnt_q,  row_cnt_d;
  logic [2*DW*N-1:0]   add_data_q, add_data_d;

  // State and datapath registers; reset discards any partial batch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      out_sum_q  <= '0;
      row_cnt_q  <= '0;
      add_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_sum_q  <= out_sum_d;
      row_cnt_q  <= row_cnt_d;
      add_data_q <= add_data_d;
    end
  end

  // Next-state and datapath update; out_sum is loaded with the final total
  // on the ACC->DONE transition so it stays frozen through DONE and IDLE.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_sum_d  = out_sum_q;
    row_cnt_d  = row_cnt_q;
    add_data_d = add_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d     = '0;
          out_sum_d = '0;
          row_cnt_d = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (in_valid) begin
          add_data_d = in_data;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        state_d = ACC;
      end
      ACC: begin
        acc_d = acc_q + {{B_BIT{1'b0}}, add_sum};
        if (row_cnt_q == LAST_ROW) begin
          out_sum_d = acc_d;
          state_d   = DONE;
        end else begin
          row_cnt_d = row_cnt_q + B_BIT'(1);
          state_d   = FETCH;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and status outputs are pure state decodes.
  always_comb begin
    in_ready  = (state_q == FETCH);
    add_en    = (state_q == ISSUE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign add_data = add_data_q;
  assign out_sum  = out_sum_q;
  assign row_cnt  = row_cnt_q;

endmodule

// File: tb/tb_mbgd_batch_sequencer.sv
// Directed bench for mbgd_batch_sequencer with a registered adder-tree model
// and a scoreboard of expected batch totals.
module tb_mbgd_batch_sequencer;

  localparam int N     = 8;
  localparam int N_BIT = 3;
  localparam int DW    = 8;
  localparam int BATCH = 4;
  localparam int B_BIT = 2;
  localparam int SW    = 2*DW + N_BIT;
  localparam int AW    = SW + B_BIT;
  localparam int RW    = 2*DW*N;

  logic              clk;
  logic              resetn;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [RW-1:0]     in_data;
  logic              add_en;
  logic [RW-1:0]     add_data;
  logic [SW-1:0]     add_sum;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_sum;
  logic              busy;
  logic [B_BIT-1:0]  row_cnt;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0]     sb[$];
  int                pulse_q[$];
  logic [2*DW-1:0]   row_val[BATCH];
  logic [AW-1:0]     last_sum;

  mbgd_batch_sequencer #(
    .N(N), .N_BIT(N_BIT), .DW(DW), .BATCH(BATCH), .B_BIT(B_BIT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .add_en(add_en), .add_data(add_data), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .row_cnt(row_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SW-1:0] rowsum(input logic [RW-1:0] d);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + SW'(d[2*DW*k +: 2*DW]);
    return s;
  endfunction

  function automatic logic [RW-1:0] mkrow(input logic [2*DW-1:0] v);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[2*DW*k +: 2*DW] = v;
    return r;
  endfunction

  // Registered adder tree: result appears on the edge that samples add_en.
  always_ff @(posedge clk) begin
    if (add_en) add_sum <= rowsum(add_data);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check({tag, "_add_en"},    64'(add_en),    64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_row_cnt"},   64'(row_cnt),   64'd0);
    check({tag, "_add_data"},  64'(|add_data), 64'd0);
    check({tag, "_out_sum"},   64'(out_sum),   64'd0);
  endtask

  // One batch from IDLE. Edges are numbered from the edge that samples start.
  task automatic run_batch(input int gap_row, input int gap_cyc, input int ready_stall,
                           input int exp_edge, input bit poke, input bit hold_start,
                           output logic [AW-1:0] final_sum);
    logic [AW-1:0] exp_sum;
    logic [AW-1:0] popped;
    int  e, acc_rows, gap_left, stall;
    bit  seen_valid, done, acc_now, hs;
    exp_sum = '0;
    for (int r = 0; r < BATCH; r++) exp_sum = exp_sum + AW'(N * int'(row_val[r]));
    sb.push_back(exp_sum);
    pulse_q.delete();
    acc_rows = 0; gap_left = gap_cyc; stall = 0; seen_valid = 0; done = 0;
    final_sum = '0;
    start = 1'b1; in_valid = 1'b1; in_data = mkrow(row_val[0]);
    out_ready = (ready_stall == 0);
    e = -1;
    while (!done) begin
      acc_now = in_ready && in_valid;
      hs      = out_valid && out_ready;
      @(posedge clk); #1;
      e++;
      if (e == 0) begin
        start = 1'b0;
        check("busy_rise", 64'(busy), 64'd1);
      end
      if (acc_now) begin
        acc_rows++;
        if (acc_rows < BATCH) in_data = mkrow(row_val[acc_rows]);
      end
      if (hs) begin
        popped = sb.pop_front();
        check("sum_after_handshake", 64'(out_sum),   64'(popped));
        check("valid_fall",          64'(out_valid), 64'd0);
        check("busy_fall",           64'(busy),      64'd0);
        final_sum = out_sum;
        done = 1;
      end else begin
        if (add_en) begin
          pulse_q.push_back(e + 1);
          check("row_cnt_issue", 64'(row_cnt), 64'(acc_rows - 1));
        end
        in_valid = 1'b1;
        if (acc_rows == gap_row && in_ready && gap_left > 0) begin
          in_valid = 1'b0;
          gap_left--;
        end
        if (out_valid) begin
          if (!seen_valid) begin
            seen_valid = 1;
            check("valid_edge", 64'(e + 1), 64'(exp_edge));
          end
          check("out_sum_done",  64'(out_sum),  64'(sb[0]));
          check("in_ready_done", 64'(in_ready), 64'd0);
          check("busy_done",     64'(busy),     64'd1);
          if (stall < ready_stall) begin
            stall++;
            out_ready = 1'b0;
            start = poke && (stall == 2);
          end else begin
            out_ready = 1'b1;
            start = hold_start;
          end
        end
      end
      if (!done && e > 300) begin
        check("timeout", 64'(e), 64'd300);
        void'(sb.pop_front());
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    check_reset_outputs("reset_init");
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Basic batch of all-ones rows.
    for (int r = 0; r < BATCH; r++) row_val[r] = 16'd1;
    run_batch(-1, 0, 0, 13, 1'b0, 1'b0, last_sum);
    check("basic_sum", 64'(last_sum), 64'd32);
    check("basic_pulse_count", 64'(pulse_q.size()), 64'd4);
    for (int i = 0; i < pulse_q.size() && i < 4; i++)
      check("basic_pulse_edge", 64'(pulse_q[i]), 64'(2 + 3*i));

    // Max operands: no wrap in the batch total.
    for (int r = 0; r < BATCH; r++) row_val[r] = 16'hFFFF;
    run_batch(-1, 0, 0, 13, 1'b0, 1'b0, last_sum);
    check("max_sum", 64'(last_sum), 64'd2097120);

    // Backpressure on input and output, with an ignored start pulse.
    row_val[0] = 16'd3; row_val[1] = 16'd7; row_val[2] = 16'd100; row_val[3] = 16'd9;
    run_batch(2, 2, 5, 15, 1'b1, 1'b0, last_sum);
    @(posedge clk); #1;
    check("idle_after_stall_busy", 64'(busy), 64'd0);
    check("idle_sum_kept", 64'(out_sum), 64'(last_sum));

    // Reset in the middle of a batch of 5s.
    start = 1'b1; in_valid = 1'b1; in_data = mkrow(16'd5); out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 50 && !(cnt == 2 && in_ready); i++) begin
        @(posedge clk); #1;
        if (add_en) cnt++;
      end
      check("pre_reset_rows", 64'(cnt), 64'd2);
      check("pre_reset_row_cnt", 64'(row_cnt), 64'd2);
    end
    #3 resetn = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int r = 0; r < BATCH; r++) row_val[r] = 16'd2;
    run_batch(-1, 0, 0, 13, 1'b0, 1'b0, last_sum);
    check("post_reset_sum", 64'(last_sum), 64'd64);

    // Back-to-back: start held through the handshake.
    for (int r = 0; r < BATCH; r++) row_val[r] = 16'd4;
    run_batch(-1, 0, 2, 13, 1'b0, 1'b1, last_sum);
    check("b2b_first", 64'(last_sum), 64'd128);
    row_val[0] = 16'd1; row_val[1] = 16'd2; row_val[2] = 16'd3; row_val[3] = 16'd4;
    run_batch(-1, 0, 0, 13, 1'b0, 1'b0, last_sum);
    check("b2b_second", 64'(last_sum), 64'd80);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
